ins_writer: RTL

Instruction-memory writer for the fetch path. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit RV32 words as `{funct7, rs2, rs1, funct3, rd, opcode}`. It then writes the words to consecutive word addresses of the instruction buffer. It is the encoding and write side of the field split performed by the decoder, and it loads programs before or between fetch runs.

---
 rtl/ins_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ins_writer.sv
// ins_writer: packs decoded RV32 instruction fields into 32-bit words and
// writes them to consecutive word addresses of the instruction buffer.
// Optional feature macro: INS_WRITER_VERIFY_EN adds a write/read-back check
// after every word, with a sticky err flag and the mem_rdata input.
module ins_writer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_in,
  input  logic [CNT_W-1:0] len_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
`ifdef INS_WRITER_VERIFY_EN
  input  logic [31:0]      mem_rdata,
  output logic             err,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

`ifdef INS_WRITER_VERIFY_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_VRFY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             start_ok;

`ifdef INS_WRITER_VERIFY_EN
  // Second VRFY cycle flag: 0 = write cycle, 1 = read-back compare cycle.
  logic             vphase;
`endif

  // Accept is decoded from state directly so in_ready stays a pure output.
  assign accept   = in_valid && (state == ST_LOAD);
  assign start_ok = start && (state == ST_IDLE);
  assign cnt_inc  = count + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the combinational in_ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = (len_in == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef INS_WRITER_VERIFY_EN
          state_next = ST_VRFY;
`else
          if (cnt_inc == len_q) state_next = ST_DONE;
`endif
        end
      end
`ifdef INS_WRITER_VERIFY_EN
      ST_VRFY: begin
        // count already includes the word under check.
        if (vphase) state_next = (count == len_q) ? ST_DONE : ST_LOAD;
      end
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered outputs: write port, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef INS_WRITER_VERIFY_EN
      err       <= 1'b0;
      vphase    <= 1'b0;
`endif
    end else begin
      mem_we <= accept;
      busy   <= (state_next != ST_IDLE);
      done   <= (state_next == ST_DONE);
      if (accept) begin
        // Address wraps naturally modulo 2^32.
        mem_addr  <= base_q + 32'(count);
        mem_wdata <= {funct7, rs2, rs1, funct3, rd, opcode};
        count     <= cnt_inc;
      end
      if (start_ok) count <= '0;
`ifdef INS_WRITER_VERIFY_EN
      vphase <= (state == ST_VRFY) && !vphase;
      if (start_ok) err <= 1'b0;
      else if ((state == ST_VRFY) && vphase && (mem_rdata != mem_wdata)) err <= 1'b1;
`endif
    end
  end

  // Session parameters, captured only when a start is honoured.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      base_q <= base_in;
      len_q  <= len_in;
    end
  end

endmodule
